csel_sub_pipe: RTL and testbench

- Pipelined subtractor built on the team's carry-select structure: computes diff = a - b - borrowIn, the inverse operation of the 16-bit carry-select adder.
- One 4-bit slice per pipeline stage. Each slice precomputes results for carry-in 0 and carry-in 1, then selects with the carry registered from the previous stage.
- Valid/ready handshake on both sides, so it sits between a streaming operand source and a result consumer in the datapath.

---
 rtl/csel_pkg.sv | 12 +
 rtl/csel_slice.sv | 24 ++
 rtl/csel_sub_pipe.sv | 142 ++++++++++++++
 tb/tb_csel_sub_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_pkg.sv
// Shared constants and helpers for the carry-select adder/subtractor pipelines.
package csel_pkg;

    localparam int CSEL_WIDTH = 16;
    localparam int CSEL_SLICE = 4;

    // Pipeline depth: one stage per slice. Width must divide evenly by slice.
    function automatic int csel_stages(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/csel_slice.sv
// One carry-select slice: dual ripple add (carry-in 0 and 1) and a late 2:1 select.
module csel_slice
    import csel_pkg::*;
#(
    parameter int SLICE = CSEL_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] res0;
    logic [SLICE:0] res1;

    // Precompute both carry-in outcomes, then pick one with the late-arriving carry.
    always_comb begin
        res0        = {1'b0, a} + {1'b0, b};
        res1        = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, 1'b1};
        {cout, sum} = cin ? res1 : res0;
    end

endmodule

// File: rtl/csel_sub_pipe.sv
// Pipelined carry-select subtractor: diff = a - b - borrowIn, one slice per stage,
// valid/ready on both sides with a global advance enable.
module csel_sub_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int SLICE = CSEL_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             overflow,
    output logic             outValid,
    input  logic             outReady
);

    localparam int STAGES = csel_stages(WIDTH, SLICE);
    localparam int MSB    = WIDTH - 1;

    // Rank k holds the operands, partial difference and carry consumed by stage k.
    logic [WIDTH-1:0]  a_q        [STAGES];
    logic [WIDTH-1:0]  a_d        [STAGES];
    logic [WIDTH-1:0]  b_q        [STAGES];
    logic [WIDTH-1:0]  b_d        [STAGES];
    logic [WIDTH-1:0]  part_q     [STAGES];
    logic [WIDTH-1:0]  part_d     [STAGES];
    logic [STAGES-1:0] cin_q;
    logic [STAGES-1:0] cin_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    // Output rank, cleared by reset so the consumer never sees stale data.
    logic [WIDTH-1:0]  diff_q;
    logic [WIDTH-1:0]  diff_d;
    logic              borrow_q;
    logic              borrow_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              out_valid_q;
    logic              out_valid_d;

    logic              adv;
    logic [SLICE-1:0]  slice_sum  [STAGES];
    logic [STAGES-1:0] slice_cout;
    logic [WIDTH-1:0]  stage_part [STAGES];

    // Subtraction as a + ~b + ~borrowIn: each stage adds its slice of a and ~b.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        csel_slice #(.SLICE(SLICE)) u_slice (
            .a    (a_q[k][k*SLICE +: SLICE]),
            .b    (~b_q[k][k*SLICE +: SLICE]),
            .cin  (cin_q[k]),
            .sum  (slice_sum[k]),
            .cout (slice_cout[k])
        );
    end

    // Next-state for every rank: shift all stages together when adv, else hold.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q, so no path through this block can infer a latch.
        a_d         = a_q;
        b_d         = b_q;
        part_d      = part_q;
        cin_d       = cin_q;
        valid_d     = valid_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;

        adv = !out_valid_q || outReady;

        for (int k = 0; k < STAGES; k++) begin
            stage_part[k]                    = part_q[k];
            stage_part[k][k*SLICE +: SLICE]  = slice_sum[k];
        end

        if (adv) begin
            a_d[0]     = a;
            b_d[0]     = b;
            part_d[0]  = '0;
            cin_d[0]   = ~borrowIn;
            valid_d[0] = inValid;
            for (int k = 1; k < STAGES; k++) begin
                a_d[k]     = a_q[k-1];
                b_d[k]     = b_q[k-1];
                part_d[k]  = stage_part[k-1];
                cin_d[k]   = slice_cout[k-1];
                valid_d[k] = valid_q[k-1];
            end
            out_valid_d = valid_q[STAGES-1];
            // Result data only moves on a real result; bubbles leave the last one in place.
            if (valid_q[STAGES-1]) begin
                diff_d   = stage_part[STAGES-1];
                borrow_d = ~slice_cout[STAGES-1];
                ovf_d    = (a_q[STAGES-1][MSB] != b_q[STAGES-1][MSB]) &&
                           (stage_part[STAGES-1][MSB] != a_q[STAGES-1][MSB]);
            end
        end
    end

    // Valid chain and visible outputs: synchronous reset discards everything in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples values from before the edge.
        if (reset) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
        end
    end

    // Datapath ranks.
    always_ff @(posedge clk) begin
        // NOTE: datapath ranks carry no reset; the valid bits qualify them, so stale contents are harmless.
        a_q    <= a_d;
        b_q    <= b_d;
        part_q <= part_d;
        cin_q  <= cin_d;
    end

    // Reset forces ready so an upstream source never stalls against a clearing pipe.
    assign inReady   = adv || reset;
    assign diff      = diff_q;
    assign borrowOut = borrow_q;
    assign overflow  = ovf_q;
    assign outValid  = out_valid_q;

endmodule

// File: tb/tb_csel_sub_pipe.sv
// Self-checking bench for csel_sub_pipe: directed boundary vectors, streaming,
// backpressure, reset mid-flight and randomized traffic against an arithmetic model.
module tb_csel_sub_pipe;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    localparam int NVEC = 7;
    localparam logic [WIDTH-1:0] VA   [NVEC] = '{16'h0005, 16'h0000, 16'h1234, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    localparam logic [WIDTH-1:0] VB   [NVEC] = '{16'h0003, 16'h0001, 16'h1234, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000};
    localparam logic             VBIN [NVEC] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [WIDTH-1:0] VD   [NVEC] = '{16'h0002, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    localparam logic             VBO  [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic             VOV  [NVEC] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } res_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrowIn;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] diff;
    logic             borrowOut;
    logic             overflow;
    logic             outValid;
    logic             outReady;

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   pop_cnt   = 0;
    res_t exp_q [$];

    csel_sub_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .borrowIn  (borrowIn),
        .inValid   (inValid),
        .inReady   (inReady),
        .diff      (diff),
        .borrowOut (borrowOut),
        .overflow  (overflow),
        .outValid  (outValid),
        .outReady  (outReady)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bin);
        res_t r;
        int   ud;
        int   sd;
        ud       = int'(x) - int'(y) - int'(bin);
        sd       = int'($signed(x)) - int'($signed(y)) - int'(bin);
        r.diff   = ud[WIDTH-1:0];
        r.borrow = (ud < 0);
        r.ovf    = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: drive inputs, sample pre-edge outputs, scoreboard any visible result, advance.
    task automatic drive_cycle(input logic v, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                               input logic bin, input logic ordy,
                               output logic acc, output logic ov, output logic ir, output res_t obs);
        res_t front;
        inValid  = v;
        a        = xa;
        b        = xb;
        borrowIn = bin;
        outReady = ordy;
        #1;
        ir         = inReady;
        ov         = outValid;
        acc        = v && inReady;
        obs.diff   = diff;
        obs.borrow = borrowOut;
        obs.ovf    = overflow;
        if (ov) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got diff=%h borrow=%b ovf=%b, expected no result in flight",
                         obs.diff, obs.borrow, obs.ovf);
            end else begin
                front = exp_q[0];
                if (obs !== front)
                    $display("FAIL sb_result: got diff=%h borrow=%b ovf=%b, expected diff=%h borrow=%b ovf=%b",
                             obs.diff, obs.borrow, obs.ovf, front.diff, front.borrow, front.ovf);
                else
                    pass_cnt++;
                if (ordy) begin
                    exp_q.delete(0);
                    pop_cnt++;
                end
            end
        end
        if (acc) exp_q.push_back(model(xa, xb, bin));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        logic acc, ov, ir;
        res_t obs;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, ir, obs);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b1; inValid = 1'b0; a = '0; b = '0; borrowIn = 1'b0; outReady = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++; if (outValid !== 1'b0)  $display("FAIL rst_valid: got %b expected 0", outValid);   else pass_cnt++;
        total_cnt++; if (diff !== '0)        $display("FAIL rst_diff: got %h expected 0000", diff);     else pass_cnt++;
        total_cnt++; if (borrowOut !== 1'b0) $display("FAIL rst_borrow: got %b expected 0", borrowOut); else pass_cnt++;
        total_cnt++; if (overflow !== 1'b0)  $display("FAIL rst_ovf: got %b expected 0", overflow);     else pass_cnt++;
        total_cnt++; if (inReady !== 1'b1)   $display("FAIL rst_ready_in: got %b expected 1", inReady); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (inReady !== 1'b1)   $display("FAIL rst_ready_after: got %b expected 1", inReady); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (outValid !== 1'b0)  $display("FAIL rst_idle_valid: got %b expected 0", outValid); else pass_cnt++;
    endtask

    // Spec boundary vectors, each sent alone: exact latency, single-cycle valid, constant results.
    task automatic test_vectors();
        logic acc, ov, ir;
        res_t obs;
        for (int i = 0; i < NVEC; i++) begin
            drive_cycle(1'b1, VA[i], VB[i], VBIN[i], 1'b1, acc, ov, ir, obs);
            total_cnt++; if (acc !== 1'b1) $display("FAIL vec%0d_accept: got %b expected 1", i, acc); else pass_cnt++;
            for (int j = 1; j <= LAT + 2; j++) begin
                drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, ir, obs);
                total_cnt++;
                if (ov !== (j == LAT + 1)) $display("FAIL vec%0d_valid_c%0d: got %b expected %b", i, j, ov, j == LAT + 1);
                else pass_cnt++;
                if (j == LAT + 1) begin
                    total_cnt++; if (obs.diff !== VD[i])    $display("FAIL vec%0d_diff: got %h expected %h", i, obs.diff, VD[i]);      else pass_cnt++;
                    total_cnt++; if (obs.borrow !== VBO[i]) $display("FAIL vec%0d_borrow: got %b expected %b", i, obs.borrow, VBO[i]); else pass_cnt++;
                    total_cnt++; if (obs.ovf !== VOV[i])    $display("FAIL vec%0d_ovf: got %b expected %b", i, obs.ovf, VOV[i]);       else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_streaming();
        logic acc, ov, ir;
        res_t obs;
        int   pops0;
        pops0 = pop_cnt;
        for (int j = 0; j < 16; j++) begin
            drive_cycle(j < 8, pick_operand(), pick_operand(), 1'($urandom), 1'b1, acc, ov, ir, obs);
            if (j < 8) begin
                total_cnt++; if (acc !== 1'b1) $display("FAIL stream_accept_c%0d: got %b expected 1", j, acc); else pass_cnt++;
            end
            total_cnt++;
            if (ov !== (j >= LAT + 1 && j < LAT + 9)) $display("FAIL stream_valid_c%0d: got %b expected %b", j, ov, j >= LAT + 1 && j < LAT + 9);
            else pass_cnt++;
        end
        total_cnt++; if (pop_cnt - pops0 !== 8) $display("FAIL stream_count: got %0d expected 8", pop_cnt - pops0); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic             acc, ov, ir, v, ordy;
        logic [WIDTH-1:0] xa, xb;
        logic             xbin;
        res_t             obs, prev;
        int               sent, pops0;
        sent  = 0;
        pops0 = pop_cnt;
        prev  = '0;
        xa = pick_operand(); xb = pick_operand(); xbin = 1'($urandom);
        for (int j = 0; j < 20; j++) begin
            v    = (sent < 6) && (j < 3 || j >= 8);
            ordy = !(j >= 6 && j <= 8);
            drive_cycle(v, xa, xb, xbin, ordy, acc, ov, ir, obs);
            if (acc) begin
                sent++;
                xa = pick_operand(); xb = pick_operand(); xbin = 1'($urandom);
            end
            if (j >= 6 && j <= 8) begin
                total_cnt++; if (ov !== 1'b1) $display("FAIL bp_valid_c%0d: got %b expected 1", j, ov); else pass_cnt++;
                total_cnt++; if (ir !== 1'b0) $display("FAIL bp_ready_c%0d: got %b expected 0", j, ir); else pass_cnt++;
                if (j > 6) begin
                    total_cnt++;
                    if (obs !== prev) $display("FAIL bp_hold_c%0d: got %h expected %h", j, obs, prev);
                    else pass_cnt++;
                end
            end
            prev = obs;
        end
        drain();
        total_cnt++; if (sent !== 6)              $display("FAIL bp_sent: got %0d expected 6", sent);               else pass_cnt++;
        total_cnt++; if (pop_cnt - pops0 !== 6)   $display("FAIL bp_count: got %0d expected 6", pop_cnt - pops0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_flight();
        logic acc, ov, ir;
        res_t obs;
        for (int j = 0; j < 3; j++)
            drive_cycle(1'b1, pick_operand(), pick_operand(), 1'($urandom), 1'b1, acc, ov, ir, obs);
        reset = 1'b1; inValid = 1'b0; outReady = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        total_cnt++; if (outValid !== 1'b0) $display("FAIL rmf_valid: got %b expected 0", outValid); else pass_cnt++;
        total_cnt++; if (diff !== '0)       $display("FAIL rmf_diff: got %h expected 0000", diff);   else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, ir, obs);
            total_cnt++; if (ov !== 1'b0) $display("FAIL rmf_ghost_c%0d: got %b expected 0", j, ov); else pass_cnt++;
        end
        drive_cycle(1'b1, 16'h00F0, 16'h000F, 1'b0, 1'b1, acc, ov, ir, obs);
        for (int j = 1; j <= LAT + 2; j++) begin
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, ir, obs);
            total_cnt++;
            if (ov !== (j == LAT + 1)) $display("FAIL rmf_new_valid_c%0d: got %b expected %b", j, ov, j == LAT + 1);
            else pass_cnt++;
            if (j == LAT + 1) begin
                total_cnt++; if (obs.diff !== 16'h00E1) $display("FAIL rmf_new_diff: got %h expected 00e1", obs.diff); else pass_cnt++;
            end
        end
        // Reset while a result sits stalled: ready is forced high and the outputs clear.
        drive_cycle(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0, acc, ov, ir, obs);
        for (int j = 1; j <= LAT; j++)
            drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, acc, ov, ir, obs);
        inValid = 1'b0; outReady = 1'b0;
        #1;
        total_cnt++; if (outValid !== 1'b1) $display("FAIL rst_stall_valid: got %b expected 1", outValid); else pass_cnt++;
        total_cnt++; if (inReady !== 1'b0)  $display("FAIL rst_stall_ready: got %b expected 0", inReady);  else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (inReady !== 1'b1)  $display("FAIL rst_force_ready: got %b expected 1", inReady);  else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        total_cnt++; if (outValid !== 1'b0) $display("FAIL rst_stall_clr_valid: got %b expected 0", outValid); else pass_cnt++;
        total_cnt++;
        if ({diff, borrowOut, overflow} !== '0) $display("FAIL rst_stall_clr_data: got %h/%b/%b expected 0000/0/0", diff, borrowOut, overflow);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic acc, ov, ir, v, ordy;
        res_t obs;
        for (int j = 0; j < 300; j++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            drive_cycle(v, pick_operand(), pick_operand(), 1'($urandom), ordy, acc, ov, ir, obs);
            total_cnt++;
            if (ir !== (!ov || ordy)) $display("FAIL rand_ready_c%0d: got %b expected %b", j, ir, !ov || ordy);
            else pass_cnt++;
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_streaming();
        test_backpressure();
        test_reset_mid_flight();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
